// File: rtl/io_dev_pkg.sv
// io_dev_pkg: register offsets and CTRL bit layout shared by the memory-mapped I/O devices
package io_dev_pkg;

    localparam logic [31:0] DATA_OFS = 32'h0;
    localparam logic [31:0] CTRL_OFS = 32'h4;

    localparam int READY_BIT   = 0;
    localparam int OVERRUN_BIT = 2;
    localparam int IE_BIT      = 8;

    function automatic logic [31:0] ctrl_word(input logic ready, input logic overrun, input logic ie);
        logic [31:0] w;
        w = '0;
        w[READY_BIT] = ready;
        w[OVERRUN_BIT] = overrun;
        w[IE_BIT] = ie;
        return w;
    endfunction

endpackage

// File: rtl/sync_debounce.sv
// sync_debounce: two-flop synchroniser plus one shared debounce counter; pulses change when a new value is accepted
module sync_debounce #(
    parameter int WIDTH           = 10,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pins,
    output logic [WIDTH-1:0] stable,
    output logic             change
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] meta_q, meta_d, sync_q, sync_d, stable_q, stable_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // Count cycles the synchronised value differs from stable; the counter restarts when sync_q is about
    // to change (meta_q already differs), so a value is accepted only after DEBOUNCE_CYCLES steady cycles
    always_comb begin
        meta_d = pins;
        sync_d = meta_q;
        stable_d = stable_q;
        cnt_d = cnt_q;
        change = 1'b0;
        if (sync_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            stable_d = sync_q;
            cnt_d = '0;
            change = 1'b1;
        end else begin
            cnt_d = (meta_q != sync_q) ? '0 : cnt_q + CW'(1);
        end
    end

    // State registers; reset discards any value still being debounced
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
            stable_q <= '0;
            cnt_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            stable_q <= stable_d;
            cnt_q <= cnt_d;
        end
    end

    assign stable = stable_q;

endmodule

// File: rtl/sw_key_io_dev.sv
// sw_key_io_dev: debounced switch/key input device with DATA and sticky CTRL/status registers
// Optional interrupt enable and IRQ output are built only when SWKEY_IRQ_EN is defined.
module sw_key_io_dev
    import io_dev_pkg::*;
#(
    parameter int                    ADDR_WIDTH      = 32,
    parameter int                    DATA_WIDTH      = 32,
    parameter int                    WIDTH           = 10,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = 32'hF0000010,
    parameter int                    DEBOUNCE_CYCLES = 500000
) (
    input  logic                  CLOCK_50,
    input  logic                  RESET,
    input  logic [WIDTH-1:0]      PINS,
    input  logic [ADDR_WIDTH-1:0] ABUS,
    input  logic                  RE,
    input  logic                  WE,
    input  logic [DATA_WIDTH-1:0] DIN,
    output logic [DATA_WIDTH-1:0] DOUT,
    output logic                  SEL,
    output logic                  IRQ
);

    logic [WIDTH-1:0] stable;
    logic             change;
    logic             hit_data, hit_ctrl, rd_data, wr_ctrl;
    logic             ready_q, ready_d, ovr_q, ovr_d, ie_q, ie_d, irq_q, irq_d;

    sync_debounce #(
        .WIDTH(WIDTH),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
        .clk(CLOCK_50),
        .rst(RESET),
        .pins(PINS),
        .stable(stable),
        .change(change)
    );

    assign hit_data = ABUS == BASE_ADDR + ADDR_WIDTH'(DATA_OFS);
    assign hit_ctrl = ABUS == BASE_ADDR + ADDR_WIDTH'(CTRL_OFS);
    assign rd_data = RE & hit_data;
    assign wr_ctrl = WE & hit_ctrl;
    assign SEL = hit_data | hit_ctrl;
    assign IRQ = irq_q;

    // Read mux; zero when unselected so several devices can be OR-ed onto the bus
    always_comb begin
        DOUT = hit_data ? DATA_WIDTH'(stable) : hit_ctrl ? DATA_WIDTH'(ctrl_word(ready_q, ovr_q, ie_q)) : '0;
    end

    // Status update: a new value always wins over a DATA read or a write-0-to-clear
    always_comb begin
        ready_d = change | (ready_q & ~rd_data & (~wr_ctrl | DIN[READY_BIT]));
        ovr_d = (change & ready_q & ~rd_data) | (ovr_q & (~wr_ctrl | DIN[OVERRUN_BIT]));
`ifdef SWKEY_IRQ_EN
        ie_d = wr_ctrl ? DIN[IE_BIT] : ie_q;
        irq_d = ready_q & ie_q;
`else
        ie_d = 1'b0;
        irq_d = 1'b0;
`endif
    end

    // Status and interrupt registers
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            ready_q <= 1'b0;
            ovr_q <= 1'b0;
            ie_q <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            ready_q <= ready_d;
            ovr_q <= ovr_d;
            ie_q <= ie_d;
            irq_q <= irq_d;
        end
    end

endmodule
